// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: wraps a valid/ack user stream into BFT packets with
// credit-based flow control and single-packet replay on request.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int DEST_LEAF             = 0,
    parameter int DEST_PORT             = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din_user,
    input  logic                    vld_user2pkt,
    output logic                    ack_pkt2user,
    input  logic [PACKET_BITS-1:0]  din_credit,
    input  logic                    resend,
    output logic [PACKET_BITS-1:0]  dout_pkt
);
    localparam int CW = NUM_ADDR_BITS + 1;
    localparam logic [NUM_LEAF_BITS-1:0] LEAF = NUM_LEAF_BITS'(DEST_LEAF);
    localparam logic [NUM_PORT_BITS-1:0] PORT = NUM_PORT_BITS'(DEST_PORT);
    localparam logic [CW:0] FUS = (CW+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CW:0] MAX = (CW+1)'(2**NUM_ADDR_BITS);

    typedef enum logic {ST_RUN, ST_RESEND} state_t;
    state_t state, state_next;
    logic [NUM_ADDR_BITS-1:0] addr_cnt;
    logic [CW-1:0] credit_cnt, credit_next;
    logic [CW:0] credit_sum;
    logic [PACKET_BITS-1:0] last_pkt, pkt;
    logic has_sent, xfer, upd;

    always_comb begin
        state_next   = (state == ST_RUN && resend) ? ST_RESEND : ST_RUN;
        ack_pkt2user = reset && state == ST_RUN && !resend && credit_cnt != '0;
        xfer         = vld_user2pkt && ack_pkt2user;
        upd          = din_credit[PACKET_BITS-1] &&
                       din_credit[PAYLOAD_BITS+NUM_ADDR_BITS +: NUM_PORT_BITS] == '0;
        // Widened by one bit so an update on top of full credit can be clamped.
        credit_sum   = {1'b0, credit_cnt} + (upd ? FUS : '0) - (CW+1)'(xfer);
        credit_next  = credit_sum > MAX ? MAX[CW-1:0] : credit_sum[CW-1:0];
        pkt          = {1'b1, LEAF, PORT, addr_cnt, din_user};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            addr_cnt   <= '0;
            credit_cnt <= MAX[CW-1:0];
            last_pkt   <= '0;
            has_sent   <= 1'b0;
            dout_pkt   <= '0;
        end else begin
            state      <= state_next;
            credit_cnt <= credit_next;
            if (xfer) begin
                addr_cnt <= addr_cnt + 1'b1;
                last_pkt <= pkt;
                has_sent <= 1'b1;
            end
            // Replay is loaded on entry so it is on the wire throughout ST_RESEND.
            dout_pkt <= xfer ? pkt : (state == ST_RUN && resend && has_sent) ? last_pkt : '0;
        end
    end
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// tb_leaf_stream_packetizer: directed and randomized checks of the packetizer
// against a cycle-level arithmetic reference model.
module tb_leaf_stream_packetizer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] din_user = '0;
    logic        vld_user2pkt = 1'b0;
    logic        ack_pkt2user;
    logic [48:0] din_credit = '0;
    logic        resend = 1'b0;
    logic [48:0] dout_pkt;

    int vectors = 0, miscompares = 0;
    int m_credit, m_addr;
    logic m_has, m_rsd;
    logic [48:0] m_last, m_dout;

    leaf_stream_packetizer #(.DEST_LEAF(3), .DEST_PORT(2)) dut (
        .clk(clk), .reset(reset), .din_user(din_user), .vld_user2pkt(vld_user2pkt),
        .ack_pkt2user(ack_pkt2user), .din_credit(din_credit), .resend(resend),
        .dout_pkt(dout_pkt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] mk(input int a, input logic [31:0] d);
        return {1'b1, 5'd3, 4'd2, 7'(a), d};
    endfunction

    function automatic logic [48:0] cred(input logic v, input logic [3:0] p);
        return {v, 5'($urandom), p, 7'($urandom), 32'($urandom)};
    endfunction

    task automatic model_reset();
        m_credit = 128; m_addr = 0; m_has = 1'b0; m_rsd = 1'b0;
        m_last = '0; m_dout = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; vld_user2pkt = 1'b1; din_credit = '0; resend = 1'b0;
        model_reset();
        #1;
        chk("rst_dout", dout_pkt, 0);
        chk("rst_ack", ack_pkt2user, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_credit", dut.credit_cnt, 128);
        chk("rst_addr", dut.addr_cnt, 0);
        reset = 1'b1;
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic [48:0] cw, input logic rs);
        logic exp_ack, x, upd;
        vld_user2pkt = v; din_user = d; din_credit = cw; resend = rs;
        #1;
        exp_ack = !m_rsd && !rs && m_credit != 0;
        chk("ack", ack_pkt2user, exp_ack);
        x = v && exp_ack;
        upd = cw[48] && cw[42:39] == 4'd0;
        m_dout = '0;
        if (!m_rsd && rs) m_dout = m_has ? m_last : '0;
        if (x) begin
            m_dout = mk(m_addr, d);
            m_last = m_dout;
            m_has = 1'b1;
            m_addr = (m_addr + 1) % 128;
        end
        m_credit = m_credit + (upd ? 64 : 0) - (x ? 1 : 0);
        if (m_credit > 128) m_credit = 128;
        m_rsd = !m_rsd && rs;
        @(posedge clk);
        #1;
        chk("dout", dout_pkt, m_dout);
        chk("credit", dut.credit_cnt, m_credit);
        chk("addr", dut.addr_cnt, m_addr);
    endtask

    initial begin
        logic [48:0] cw;
        do_reset();
        cycle(1'b1, 32'hDEADBEEF, '0, 1'b0);
        chk("first_pkt", dout_pkt, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
        chk("first_credit", dut.credit_cnt, 127);
        cycle(1'b0, '0, '0, 1'b0);

        do_reset();
        for (int i = 0; i < 130; i++) cycle(1'b1, $urandom, '0, 1'b0);
        chk("starved_ack", ack_pkt2user, 0);
        cycle(1'b0, '0, cred(1'b1, 4'd0), 1'b0);
        cycle(1'b1, 32'h12345678, '0, 1'b0);
        chk("wrap_pkt", dout_pkt, {1'b1, 5'd3, 4'd2, 7'd0, 32'h12345678});

        do_reset();
        cycle(1'b1, 32'hA5A5_0001, '0, 1'b0);
        cycle(1'b1, 32'h1111_2222, '0, 1'b1);
        chk("replay_pkt", dout_pkt, {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_0001});
        cycle(1'b1, 32'h3333_4444, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);

        do_reset();
        cycle(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0);

        do_reset();
        for (int i = 0; i < 28; i++) cycle(1'b1, $urandom, '0, 1'b0);
        chk("credit_100", dut.credit_cnt, 100);
        cycle(1'b1, $urandom, cred(1'b1, 4'd0), 1'b0);
        chk("sat_credit", dut.credit_cnt, 128);
        cycle(1'b1, $urandom, '0, 1'b0);
        cycle(1'b0, '0, cred(1'b1, 4'd5), 1'b0);
        chk("port5_ignored", dut.credit_cnt, 127);
        cycle(1'b0, '0, cred(1'b0, 4'd0), 1'b0);

        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, '0, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_dout", dout_pkt, 0);
        chk("midrst_ack", ack_pkt2user, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_credit", dut.credit_cnt, 128);
        cycle(1'b1, 32'hCAFE_F00D, '0, 1'b0);
        chk("midrst_pkt", dout_pkt, {1'b1, 5'd3, 4'd2, 7'd0, 32'hCAFE_F00D});

        for (int i = 0; i < 400; i++) begin
            cw = cred(1'b1, 4'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) cw[48] = 1'b0;
            cycle(1'($urandom_range(0, 3) != 0), $urandom, cw, 1'($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
